// File: rtl/core_ldst_mult_seq.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first and
// issues one register/address beat per valid/ready handshake toward the ldst unit.
module core_ldst_mult_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       regs,
  input  logic              increment,
  input  logic              pre_index,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [3:0]        req_reg,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_last,
  output logic              pc_in_list,
  output logic [ADDR_W-1:0] wb_value,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state, state_nx;
  logic [15:0]       pending;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        n;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_raw;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        low_idx;
  logic              one_left;
  logic              fire;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + 5'(regs[i]);
    end
    span = ADDR_W'({n, 2'b00});
    unique case ({increment, pre_index})
      2'b10:   start_raw = base;
      2'b11:   start_raw = base + FOUR;
      2'b00:   start_raw = base - span + FOUR;
      default: start_raw = base - span;
    endcase
    start_addr = {start_raw[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    low_idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (pending[i-1]) low_idx = 4'(i - 1);
    end
    one_left = (pending != '0) && ((pending & (pending - 16'd1)) == '0);
  end

  assign req_valid = (state == XFER) && (pending != '0);
  assign fire      = req_valid && req_ready;

  // An empty list still spends one cycle in XFER (with no beat), which gives
  // the two-cycle start->done latency for n=0.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = XFER;
      XFER:    if ((pending == '0) || (fire && one_left)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      addr       <= '0;
      wb_value   <= '0;
      pc_in_list <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) begin
        pending    <= regs;
        addr       <= start_addr;
        wb_value   <= increment ? (base + span) : (base - span);
        pc_in_list <= regs[15];
      end else if (fire) begin
        pending <= pending & ~(16'b1 << low_idx);
        addr    <= addr + FOUR;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign req_reg  = req_valid ? low_idx : '0;
  assign req_addr = req_valid ? addr : '0;
  assign req_last = req_valid && one_left;

endmodule

// File: tb/tb_core_ldst_mult_seq.sv
// Scoreboard bench for core_ldst_mult_seq: stimulus pushes expected beats and
// completion records; a negedge monitor pops and compares as the DUT responds.
module tb_core_ldst_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] regs;
  logic        increment;
  logic        pre_index;
  logic [31:0] base;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_reg;
  logic [31:0] req_addr;
  logic        req_last;
  logic        pc_in_list;
  logic [31:0] wb_value;
  logic        done;

  core_ldst_mult_seq #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .regs       (regs),
    .increment  (increment),
    .pre_index  (pre_index),
    .base       (base),
    .busy       (busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_reg    (req_reg),
    .req_addr   (req_addr),
    .req_last   (req_last),
    .pc_in_list (pc_in_list),
    .wb_value   (wb_value),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic        l;
  } beat_t;

  typedef struct {
    logic [31:0] wb;
    logic        pc;
    int          n;
    int          start_cyc;
  } end_t;

  beat_t beats[$];
  end_t  ends[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fires    = 0;
  int ready_mode = 0;
  bit seen_first = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: an n-register block occupies n consecutive words; the lowest
  // word sits at base (IA), base+4 (IB), base-4n+4 (DA) or base-4n (DB), and
  // registers map to ascending words in ascending register order.
  task automatic push_model(input logic [15:0] r, input logic inc, input logic pre,
                            input logic [31:0] b, input int sc);
    int          cnt;
    int          k;
    logic [31:0] lowest;
    beat_t       bt;
    end_t        en;
    cnt = 0;
    for (int i = 0; i < 16; i++) if (r[i]) cnt++;
    if (inc) lowest = pre ? b + 32'd4 : b;
    else     lowest = pre ? b - 32'(4 * cnt) : b - 32'(4 * cnt) + 32'd4;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (r[i]) begin
        bt.r = 4'(i);
        bt.a = (lowest + 32'(4 * k)) & 32'hFFFF_FFFC;
        bt.l = (k == cnt - 1);
        beats.push_back(bt);
        k++;
      end
    end
    en.wb        = inc ? b + 32'(4 * cnt) : b - 32'(4 * cnt);
    en.pc        = r[15];
    en.n         = cnt;
    en.start_cyc = sc;
    ends.push_back(en);
  endtask

  task automatic launch(input logic [15:0] r, input logic inc, input logic pre,
                        input logic [31:0] b);
    @(posedge clk); #1;
    check("busy_before_start", busy, 0);
    regs      = r;
    increment = inc;
    pre_index = pre;
    base      = b;
    start     = 1'b1;
    push_model(r, inc, pre, b, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    regs  = $urandom;
    base  = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (ends.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("sequence_timeout", 32'(ends.size()), 0);
    if (ends.size() != 0) begin
      beats.delete();
      ends.delete();
    end
  endtask

  // Ready driver
  initial begin
    req_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       req_ready = 1'b1;
        1:       req_ready = ~req_ready;
        default: req_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    beat_t       exp_b;
    end_t        exp_e;
    bit          prev_stall;
    logic [3:0]  held_reg;
    logic [31:0] held_addr;
    logic        held_last;
    int          last_fire_cyc;
    prev_stall    = 1'b0;
    last_fire_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
        seen_first = 1'b0;
      end else begin
        if (req_valid) begin
          check("busy_during_beat", busy, 1);
          if (ends.size() == 0) begin
            check("unexpected_req_valid", req_valid, 0);
          end else if (!seen_first) begin
            check("first_beat_latency", 32'(cyc), 32'(ends[0].start_cyc + 1));
            seen_first = 1'b1;
          end
          if (prev_stall) begin
            check("stall_reg_stable", req_reg, held_reg);
            check("stall_addr_stable", req_addr, held_addr);
            check("stall_last_stable", req_last, held_last);
          end
          if (req_ready) begin
            if (beats.size() == 0) begin
              check("beat_without_expectation", 1, 0);
            end else begin
              exp_b = beats.pop_front();
              check("req_reg", req_reg, exp_b.r);
              check("req_addr", req_addr, exp_b.a);
              check("req_last", req_last, exp_b.l);
            end
            fires++;
            last_fire_cyc = cyc;
          end
        end else if (prev_stall) begin
          check("valid_dropped_in_stall", req_valid, 1);
        end
        prev_stall = req_valid && !req_ready;
        held_reg   = req_reg;
        held_addr  = req_addr;
        held_last  = req_last;
        if (done) begin
          if (ends.size() == 0) begin
            check("unexpected_done", done, 0);
          end else begin
            exp_e = ends.pop_front();
            check("wb_value", wb_value, exp_e.wb);
            check("pc_in_list", pc_in_list, exp_e.pc);
            check("beats_left_at_done", 32'(beats.size()), 0);
            check("done_req_valid", req_valid, 0);
            if (exp_e.n == 0) check("empty_done_latency", 32'(cyc), 32'(exp_e.start_cyc + 2));
            else              check("done_latency", 32'(cyc), 32'(last_fire_cyc + 1));
          end
          seen_first = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [15:0] r;
    int          t;
    rst = 1'b1; start = 1'b0; regs = '0; increment = 1'b1; pre_index = 1'b0; base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_reg", req_reg, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_last", req_last, 0);
    check("rst_pc_in_list", pc_in_list, 0);
    check("rst_wb_value", wb_value, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    ready_mode = 0;
    launch(16'h0013, 1'b1, 1'b0, 32'h1000); wait_idle();
    launch(16'h8001, 1'b0, 1'b1, 32'h2000); wait_idle();
    launch(16'h0006, 1'b1, 1'b1, 32'h0100); wait_idle();
    launch(16'h0006, 1'b0, 1'b0, 32'h0100); wait_idle();
    ready_mode = 1;
    launch(16'hFFFF, 1'b1, 1'b0, 32'h0000); wait_idle();
    ready_mode = 0;
    launch(16'h0000, 1'b1, 1'b0, 32'h0500); wait_idle();

    // Reset in the middle of a transfer, after the second handshake
    ready_mode = 1;
    fires = 0;
    launch(16'h0013, 1'b1, 1'b0, 32'h1000);
    t = 0;
    while (fires < 2 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("midseq_two_beats", 32'(fires), 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_req_valid", req_valid, 0);
    check("midrst_req_addr", req_addr, 0);
    check("midrst_wb_value", wb_value, 0);
    check("midrst_done", done, 0);
    beats.delete();
    ends.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    launch(16'h0013, 1'b1, 1'b0, 32'h1000); wait_idle();

    // start held through the busy span including the done cycle is ignored
    launch(16'h00F0, 1'b1, 1'b0, 32'h3000);
    start = 1'b1;
    regs  = 16'h0F0F;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      ready_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0:       r = 16'h0000;
        1:       r = 16'hFFFF;
        2:       r = 16'h1 << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      launch(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom);
      wait_idle();
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
